// File: rtl/sub_serial_16.sv
// rtl/sub_serial_16.sv - nibble-serial subtractor D = A - B - Bin with valid/ready handshake
module sub_serial_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [IW+1:0]    sh;
    logic [3:0]       a_sl;
    logic [3:0]       b_sl;
    logic [4:0]       sum5;
    logic [WIDTH-1:0] d_next;

    // Subtraction as a + ~b + carry, where carry starts as ~bin and means "no borrow".
    always_comb begin
        sh     = {idx, 2'b00};
        a_sl   = 4'(a_q >> sh);
        b_sl   = 4'(b_q >> sh);
        sum5   = {1'b0, a_sl} + {1'b0, ~b_sl} + {4'b0000, carry};
        d_next = (d & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(sum5[3:0]) << sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            d         <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= ~bin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    d     <= d_next;
                    carry <= sum5[4];
                    idx   <= idx + 1'b1;
                    if (idx == IW'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bout      <= ~sum5[4];
                        zero      <= (d_next == '0);
                        ovf       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                     (d_next[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_16.sv
// tb/tb_sub_serial_16.sv - scoreboard bench for sub_serial_16 against an integer reference model
module tb_sub_serial_16;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    sub_serial_16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .zero(zero), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        exp_t r;
        int ua, ub, sa, sb_i, diff, sdiff;
        ua    = int'(av);
        ub    = int'(bv);
        sa    = int'($signed(av));
        sb_i  = int'($signed(bv));
        diff  = ua - ub - int'(bi);
        sdiff = sa - sb_i - int'(bi);
        r.d    = diff[15:0];
        r.bout = (ua < ub + int'(bi));
        r.zero = (r.d == 16'h0);
        r.ovf  = (sdiff > 32767) || (sdiff < -32768);
        return r;
    endfunction

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got d=%0h with empty scoreboard", d);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("d", 32'(d), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bout));
                check("zero", 32'(zero), 32'(e.zero));
                check("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic bi, input int hold);
        int cnt;
        logic [18:0] snap;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        out_ready = (hold == 0);
        sb.push_back(model(av, bv, bi));
        @(posedge clk); #1;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            @(posedge clk); #1; cnt++;
        end
        check("latency", 32'(cnt), 32'(N));
        if (hold > 0) begin
            snap = {d, bout, zero, ovf};
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
                @(posedge clk); #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_outputs", 32'({d, bout, zero, ovf}), 32'(snap));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("consumed_valid", 32'(out_valid), 32'd0);
        check("consumed_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({d, bout, zero, ovf}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h0234, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
        do_op(16'h0005, 16'h0004, 1'b1, 0);
        do_op(16'hABCD, 16'h1234, 1'b1, 3);
        do_op(16'h8000, 16'h0000, 1'b1, 1);

        // Reset during the second RUN cycle discards the pending operation.
        do begin @(posedge clk); #1; end while (!in_ready);
        a = 16'h1234; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        sb.push_back(model(16'h1234, 16'h0001, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'({d, bout, zero, ovf}), 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'h0010, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 20; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
